// File: rtl/dsp_mac_sequencer.sv
// dsp_mac_sequencer: sequences one DSP48A1 slice as a length-N multiply-accumulate.
//
// The A/B data path goes straight to the slice. This block only drives
// OPMODE, the clock enables and the P-register reset.
// A shift register tracks which products are in flight, so P accumulates
// only on valid products. Source stalls insert harmless bubbles.
//
// Handshake: s_ready depends on state alone (high only in RUN). A pair is
// accepted on any cycle where s_valid and s_ready are both high. A
// same-cycle abort overrides the accept.
//
// Optional feature: define DSP_SEQ_SUB_EN to add the 'sub' input. When sub
// is set with start, CLR loads OPMODE 8'h89 (post-adder subtract), so P
// ends at -(sum of A*B).
//
// state_dbg exposes the FSM state for checkers.

module dsp_mac_sequencer #(
    parameter int LEN_WIDTH   = 8,
    parameter int PIPE_STAGES = 2
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 start,
    input  logic [LEN_WIDTH-1:0] len,
    input  logic                 abort,
`ifdef DSP_SEQ_SUB_EN
    input  logic                 sub,
`endif
    input  logic                 s_valid,
    output logic                 s_ready,
    output logic [7:0]           OPMODE,
    output logic                 CE_IN,
    output logic                 CEM,
    output logic                 CEP,
    output logic                 RSTP,
    output logic                 busy,
    output logic                 done,
    output logic [2:0]           state_dbg
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLR   = 3'd1,
        RUN   = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [7:0] OPMODE_ADD = 8'h09;  // X=M, Z=P, add
    localparam logic [7:0] OPMODE_SUB = 8'h89;  // same, post-adder subtract

    state_t                 state;
    state_t                 state_next;
    logic [LEN_WIDTH-1:0]   count;
    logic [PIPE_STAGES-1:0] vld;
    logic [7:0]             opmode_q;
    logic                   rstp_abort_q;
    logic                   accept;
    logic                   abort_hit;
    logic                   sub_sel;

    // Abort only acts outside IDLE. In IDLE it is ignored and start wins.
    assign abort_hit = abort && (state != IDLE);

`ifdef DSP_SEQ_SUB_EN
    logic sub_q;

    // Latch the subtract request together with the start command.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sub_q <= 1'b0;
        end else if (state == IDLE && start) begin
            sub_q <= sub;
        end
    end

    assign sub_sel = sub_q;
`else
    assign sub_sel = 1'b0;
`endif

    // FSM state register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and the accept decision.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = CLR;
                end
            end
            CLR: begin
                // count already holds the length latched with start.
                if (count != '0) begin
                    state_next = RUN;
                end else begin
                    state_next = DONE;
                end
            end
            RUN: begin
                accept = s_valid && !abort;
                if (accept && count == LEN_WIDTH'(1)) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                // Wait until the last product has been added into P.
                if (vld == '0) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        if (abort_hit) begin
            state_next = IDLE;
        end
    end

    // Remaining-sample counter: load on start, count down per accept, clear on abort.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            count <= '0;
        end else if (abort_hit) begin
            count <= '0;
        end else if (state == IDLE && start) begin
            count <= len;
        end else if (accept && count != '0) begin
            count <= count - LEN_WIDTH'(1);
        end
    end

    // Product-occupancy shift register: bit i marks a valid product i+1 stages past the inputs.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            vld <= '0;
        end else if (abort_hit) begin
            vld <= '0;
        end else begin
            vld[0] <= accept;
            for (int i = 1; i < PIPE_STAGES; i++) begin
                vld[i] <= vld[i-1];
            end
        end
    end

    // OPMODE is loaded in CLR and then held until the next CLR.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            opmode_q <= 8'h00;
        end else if (state == CLR) begin
            opmode_q <= sub_sel ? OPMODE_SUB : OPMODE_ADD;
        end
    end

    // After an abort, P is reset for one cycle while the FSM is already in IDLE.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rstp_abort_q <= 1'b0;
        end else begin
            rstp_abort_q <= abort_hit;
        end
    end

    // Output decode.
    always_comb begin
        s_ready   = (state == RUN);
        CE_IN     = accept;
        CEM       = vld[0];
        CEP       = vld[PIPE_STAGES-1];
        RSTP      = (state == CLR) || rstp_abort_q;
        busy      = (state != IDLE);
        done      = (state == DONE) && !abort;
        OPMODE    = opmode_q;
        state_dbg = state;
    end

endmodule
